sevenseg_capture: RTL and testbench

SEVENSEG_CAPTURE -- requirements
Module: sevenseg_capture

---
 rtl/sevenseg_pkg.sv | 53 +++++
 rtl/sevenseg_digit_rx.sv | 89 ++++++++
 rtl/sevenseg_capture.sv | 100 ++++++++++
 tb/tb_sevenseg_capture.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: values shared by the seven-segment display driver and the
// capture block. Holds the 16 hex glyphs (active-low, bit 6 = a ... bit 0 = g),
// the per-digit receive FSM state type, and the glyph decoder.
package sevenseg_pkg;

  localparam logic [6:0] GLYPH_0 = 7'b0000001;
  localparam logic [6:0] GLYPH_1 = 7'b1001111;
  localparam logic [6:0] GLYPH_2 = 7'b0010010;
  localparam logic [6:0] GLYPH_3 = 7'b0000110;
  localparam logic [6:0] GLYPH_4 = 7'b1001100;
  localparam logic [6:0] GLYPH_5 = 7'b0100100;
  localparam logic [6:0] GLYPH_6 = 7'b0100000;
  localparam logic [6:0] GLYPH_7 = 7'b0001111;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0000100;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b1100000;
  localparam logic [6:0] GLYPH_C = 7'b0110001;
  localparam logic [6:0] GLYPH_D = 7'b1000010;
  localparam logic [6:0] GLYPH_E = 7'b0110000;
  localparam logic [6:0] GLYPH_F = 7'b0111000;

  // Entry i is the glyph for nibble i.
  localparam logic [15:0][6:0] GLYPH_TAB = {
    GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
    GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
  };

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_SETTLE = 2'd1,
    RX_HELD   = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic       ok;
    logic [3:0] nib;
  } glyph_t;

  // Pattern -> nibble; ok=0 for anything that is not one of the 16 glyphs.
  function automatic glyph_t glyph_decode(input logic [6:0] seg_n);
    glyph_t r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (seg_n == GLYPH_TAB[i]) begin
        r.ok  = 1'b1;
        r.nib = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sevenseg_digit_rx.sv
// sevenseg_digit_rx: receive path for one multiplexed digit.
// Double-flop synchroniser, IDLE/SETTLE/HELD stability FSM and stale timer.
//   clk, reset      clock, async active-low reset
//   an_n, seg_n     raw anode enable and abcdefg segment lines (active-low)
//   kill            bus contention seen this cycle; force IDLE, no accept
//   an_act          synchronised anode, active-high (used for contention)
//   accept, nib     one-cycle pulse with the decoded nibble of a legal glyph
//   bad             one-cycle pulse: stable pattern is not a legal glyph
//   stale           no accept for TIMEOUT_CYCLES cycles
module sevenseg_digit_rx
  import sevenseg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       an_n,
  input  logic [6:0] seg_n,
  input  logic       kill,
  output logic       an_act,
  output logic       accept,
  output logic       bad,
  output logic [3:0] nib,
  output logic       stale
);
  localparam int             TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]     STABLE = 8'(STABLE_CYCLES);
  localparam logic [TW-1:0]  TMAX   = TW'(TIMEOUT_CYCLES);

  // Anode is synchronised inverted so that cleared flops read as "inactive".
  logic [1:0]      an_sync;
  logic [1:0][6:0] seg_sync;
  rx_state_e       st, st_n;
  logic [6:0]      pat, pat_n;
  logic [7:0]      cnt, cnt_n;
  logic [TW-1:0]   tcnt;
  glyph_t          dec;

  assign an_act = an_sync[1];
  assign stale  = (tcnt == TMAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_sync  <= '0;
      seg_sync <= '0;
      st       <= RX_IDLE;
      pat      <= '0;
      cnt      <= '0;
      tcnt     <= '0;
    end else begin
      an_sync  <= {an_sync[0], ~an_n};
      seg_sync <= {seg_sync[0], seg_n};
      st       <= st_n;
      pat      <= pat_n;
      cnt      <= cnt_n;
      if (accept)            tcnt <= '0;
      else if (tcnt != TMAX) tcnt <= tcnt + TW'(1);
    end
  end

  always_comb begin
    st_n   = st;
    pat_n  = pat;
    cnt_n  = cnt;
    accept = 1'b0;
    bad    = 1'b0;
    dec    = glyph_decode(seg_sync[1]);
    nib    = dec.nib;
    if (kill || !an_sync[1]) begin
      st_n  = RX_IDLE;
      cnt_n = '0;
    end else if (st == RX_IDLE || seg_sync[1] != pat) begin
      // fresh activation or a new pattern: restart the stability run
      st_n  = RX_SETTLE;
      pat_n = seg_sync[1];
      cnt_n = 8'd1;
    end else if (st == RX_SETTLE) begin
      cnt_n = cnt + 8'd1;
    end
    // Checked on the next-state so STABLE_CYCLES=1 accepts on first sample.
    if (st_n == RX_SETTLE && cnt_n == STABLE) begin
      st_n   = RX_HELD;
      accept = dec.ok;
      bad    = ~dec.ok;
    end
  end

endmodule

// File: rtl/sevenseg_capture.sv
// sevenseg_capture: captures a two-digit multiplexed seven-segment display
// back into a byte. Each digit has its own receiver; this level pairs the
// nibbles, raises byte_valid and merges the error sources into pat_err.
//   clk, reset           clock, async active-low reset
//   an0/an1              digit anode enables (active-low)
//   a0..g0 / a1..g1      segment lines (active-low)
//   byte_out, byte_valid last paired value {digit1, digit0} and update pulse
//   stale[1:0]           per-digit timeout flags
//   pat_err              illegal stable glyph or anode contention
//   err_count[7:0]       saturating pat_err count, only when
//                        SEVENSEG_CAPTURE_ERRCNT_EN is defined
module sevenseg_capture
  import sevenseg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       an0,
  input  logic       an1,
  input  logic       a0, b0, c0, d0, e0, f0, g0,
  input  logic       a1, b1, c1, d1, e1, f1, g1,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic [1:0] stale,
  output logic       pat_err
`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);
  localparam int NUM_DIGITS = 2;

  logic [NUM_DIGITS-1:0]      an_n, an_act, accept, bad, fresh, fresh_n;
  logic [NUM_DIGITS-1:0][6:0] seg_n;
  logic [NUM_DIGITS-1:0][3:0] nib_dec, nib_q, nib_n;
  logic                       contention, err_n;

  assign an_n       = {an1, an0};
  assign seg_n      = {{a1, b1, c1, d1, e1, f1, g1}, {a0, b0, c0, d0, e0, f0, g0}};
  assign contention = &an_act;
  assign err_n      = (|bad) | contention;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    sevenseg_digit_rx #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
      .clk   (clk),
      .reset (reset),
      .an_n  (an_n[i]),
      .seg_n (seg_n[i]),
      .kill  (contention),
      .an_act(an_act[i]),
      .accept(accept[i]),
      .bad   (bad[i]),
      .nib   (nib_dec[i]),
      .stale (stale[i])
    );
  end

  // Accepts this cycle merge in before the pairing test, so simultaneous
  // accepts pair immediately and a re-accept overwrites the waiting nibble.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      fresh_n[i] = fresh[i] | accept[i];
      nib_n[i]   = accept[i] ? nib_dec[i] : nib_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nib_q      <= '0;
      fresh      <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      pat_err    <= 1'b0;
    end else begin
      nib_q   <= nib_n;
      pat_err <= err_n;
      if (&fresh_n) begin
        byte_out   <= nib_n;
        byte_valid <= 1'b1;
        fresh      <= '0;
      end else begin
        byte_valid <= 1'b0;
        fresh      <= fresh_n;
      end
    end
  end

`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                           err_count <= '0;
    else if (err_n && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_sevenseg_capture.sv
`timescale 1ns/1ps
module tb_sevenseg_capture;
  localparam int STABLE = 4;
  localparam int TOUT   = 16;

  typedef struct { bit act0; bit act1; logic [6:0] p0; logic [6:0] p1; } smp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       an0 = 1'b1, an1 = 1'b1;
  logic [6:0] s0 = 7'h7f, s1 = 7'h7f;
  logic [7:0] byte_out;
  logic       byte_valid, pat_err;
  logic [1:0] stale;
`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
  logic [7:0] err_count;
`endif

  int checks = 0, errors = 0;
  int vcount = 0, ecount = 0;

  // reference model state: run length of identical active samples per digit
  smp_t       q1, q2;
  int         run [2];
  logic [6:0] last [2];
  bit         mfresh [2];
  logic [3:0] mnib [2];
  int         tout [2];
  logic [7:0] m_byte;
  bit         m_valid, m_err;
  logic [1:0] m_stale;
  int         m_errcnt;

  always #5 clk = ~clk;

  sevenseg_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .reset(reset), .an0(an0), .an1(an1),
    .a0(s0[6]), .b0(s0[5]), .c0(s0[4]), .d0(s0[3]), .e0(s0[2]), .f0(s0[1]), .g0(s0[0]),
    .a1(s1[6]), .b1(s1[5]), .c1(s1[4]), .d1(s1[3]), .e1(s1[2]), .f1(s1[1]), .g1(s1[0]),
    .byte_out(byte_out), .byte_valid(byte_valid), .stale(stale), .pat_err(pat_err)
`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  // lit segments of each hex glyph as drawn on a display
  function automatic string lit_of(input int n);
    case (n)
      0: return "abcdef";   1: return "bc";      2: return "abdeg";   3: return "abcdg";
      4: return "bcfg";     5: return "acdfg";   6: return "acdefg";  7: return "abc";
      8: return "abcdefg";  9: return "abcdfg";  10: return "abcefg"; 11: return "cdefg";
      12: return "adef";    13: return "bcdeg";  14: return "adefg";  default: return "aefg";
    endcase
  endfunction

  function automatic logic [6:0] seg_of(input string s);
    logic [6:0] r;
    r = 7'h7f;
    for (int i = 0; i < s.len(); i++) r[6 - (int'(s[i]) - 97)] = 1'b0;
    return r;
  endfunction

  function automatic int glyph_val(input logic [6:0] p);
    for (int k = 0; k < 16; k++) if (seg_of(lit_of(k)) == p) return k;
    return -1;
  endfunction

  function automatic logic [6:0] rand_pat();
    if ($urandom_range(0, 4) == 0) return 7'($urandom);
    return seg_of(lit_of(int'($urandom_range(0, 15))));
  endfunction

  task automatic model_clear();
    q1 = '{0, 0, 7'h7f, 7'h7f};
    q2 = q1;
    for (int i = 0; i < 2; i++) begin
      run[i] = 0; last[i] = 7'h7f; mfresh[i] = 0; mnib[i] = 4'h0; tout[i] = 0;
    end
    m_byte = 8'h00; m_valid = 0; m_err = 0; m_stale = 2'b00; m_errcnt = 0;
  endtask

  // One clock: drive inputs, advance the model at the edge, sample at negedge.
  // Inputs reach the decision logic two edges after being driven.
  task automatic tick(input bit x0, input bit x1, input logic [6:0] p0, input logic [6:0] p1);
    smp_t s;
    bit both, acc;
    bit act [2];
    logic [6:0] p [2];
    int v;
    an0 = ~x0; an1 = ~x1; s0 = p0; s1 = p1;
    @(posedge clk);
    if (!reset) model_clear();
    else begin
      s = q2; q2 = q1; q1 = '{x0, x1, p0, p1};
      act[0] = s.act0; act[1] = s.act1; p[0] = s.p0; p[1] = s.p1;
      both = s.act0 && s.act1;
      m_err = both;
      for (int i = 0; i < 2; i++) begin
        acc = 0;
        if (!act[i] || both) run[i] = 0;
        else if (run[i] > 0 && p[i] == last[i]) run[i]++;
        else begin run[i] = 1; last[i] = p[i]; end
        if (run[i] == STABLE) begin
          v = glyph_val(p[i]);
          if (v >= 0) begin acc = 1; mnib[i] = 4'(v); mfresh[i] = 1; end
          else m_err = 1;
        end
        if (acc) tout[i] = 0;
        else if (tout[i] < TOUT) tout[i]++;
      end
      m_valid = 0;
      if (mfresh[0] && mfresh[1]) begin
        m_valid = 1; m_byte = {mnib[1], mnib[0]}; mfresh[0] = 0; mfresh[1] = 0;
      end
      if (m_err && m_errcnt < 255) m_errcnt++;
      m_stale = {tout[1] == TOUT, tout[0] == TOUT};
    end
    @(negedge clk);
    if (byte_valid) vcount++;
    if (pat_err) ecount++;
  endtask

  task automatic drive(input int n, input bit x0, input bit x1, input logic [6:0] p0, input logic [6:0] p1);
    for (int i = 0; i < n; i++) tick(x0, x1, p0, p1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(2, 0, 0, 7'h7f, 7'h7f);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(3, 0, 0, 7'h7f, 7'h7f);
    checks++; if (byte_out !== 8'h00) begin errors++; $display("FAIL reset_byte_out got %h want 00", byte_out); end
    checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL reset_byte_valid got %b want 0", byte_valid); end
    checks++; if (stale !== 2'b00) begin errors++; $display("FAIL reset_stale got %b want 00", stale); end
    checks++; if (pat_err !== 1'b0) begin errors++; $display("FAIL reset_pat_err got %b want 0", pat_err); end
`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
    checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL reset_err_count got %h want 00", err_count); end
`endif
    reset = 1'b1;
  endtask

  task automatic test_pair();
    do_reset();
    vcount = 0;
    drive(8, 1, 0, seg_of(lit_of(3)), 7'h7f);
    drive(8, 0, 1, 7'h7f, seg_of(lit_of(10)));
    drive(4, 0, 0, 7'h7f, 7'h7f);
    checks++; if (vcount != 1) begin errors++; $display("FAIL pair_pulses got %0d want 1", vcount); end
    checks++; if (byte_out !== 8'hA3) begin errors++; $display("FAIL pair_byte got %h want a3", byte_out); end
    checks++; if (stale !== 2'b00) begin errors++; $display("FAIL pair_stale got %b want 00", stale); end
  endtask

  task automatic test_toggle();
    do_reset();
    drive(6, 0, 1, 7'h7f, seg_of(lit_of(7)));
    drive(2, 0, 0, 7'h7f, 7'h7f);
    vcount = 0;
    for (int i = 0; i < 5; i++) begin
      drive(2, 1, 0, seg_of(lit_of(1)), 7'h7f);
      drive(2, 1, 0, seg_of(lit_of(2)), 7'h7f);
    end
    drive(3, 0, 0, 7'h7f, 7'h7f);
    checks++; if (vcount != 0) begin errors++; $display("FAIL toggle_no_accept got %0d pulses want 0", vcount); end
    drive(6, 1, 0, seg_of(lit_of(2)), 7'h7f);
    drive(2, 0, 0, 7'h7f, 7'h7f);
    checks++; if (vcount != 1) begin errors++; $display("FAIL toggle_then_stable got %0d pulses want 1", vcount); end
    checks++; if (byte_out !== 8'h72) begin errors++; $display("FAIL toggle_byte got %h want 72", byte_out); end
  endtask

  task automatic test_illegal();
    vcount = 0; ecount = 0;
    drive(6, 1, 0, 7'b1010101, 7'h7f);
    drive(3, 0, 0, 7'h7f, 7'h7f);
    checks++; if (ecount != 1) begin errors++; $display("FAIL illegal_pat_err got %0d pulses want 1", ecount); end
    checks++; if (byte_out !== 8'h72) begin errors++; $display("FAIL illegal_byte got %h want 72", byte_out); end
    checks++; if (vcount != 0) begin errors++; $display("FAIL illegal_valid got %0d pulses want 0", vcount); end
  endtask

  task automatic test_stale();
    do_reset();
    drive(TOUT - 1, 0, 0, 7'h7f, 7'h7f);
    checks++; if (stale !== 2'b00) begin errors++; $display("FAIL stale_early got %b want 00", stale); end
    drive(1, 0, 0, 7'h7f, 7'h7f);
    checks++; if (stale !== 2'b11) begin errors++; $display("FAIL stale_set got %b want 11", stale); end
    drive(6, 1, 0, seg_of(lit_of(5)), 7'h7f);
    checks++; if (stale !== 2'b10) begin errors++; $display("FAIL stale_clear got %b want 10", stale); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(6, 0, 1, 7'h7f, seg_of(lit_of(12)));
    drive(2, 0, 0, 7'h7f, 7'h7f);
    drive(5, 1, 0, seg_of(lit_of(9)), 7'h7f);
    reset = 1'b0;
    #1;
    checks++; if (byte_out !== 8'h00) begin errors++; $display("FAIL midrst_byte got %h want 00", byte_out); end
    checks++; if (byte_valid !== 1'b0 || pat_err !== 1'b0) begin errors++; $display("FAIL midrst_pulses got %b%b want 00", byte_valid, pat_err); end
    checks++; if (stale !== 2'b00) begin errors++; $display("FAIL midrst_stale got %b want 00", stale); end
    drive(2, 1, 0, seg_of(lit_of(9)), 7'h7f);
    reset = 1'b1;
    drive(6, 0, 1, 7'h7f, seg_of(lit_of(12)));
    drive(2, 0, 0, 7'h7f, 7'h7f);
    vcount = 0;
    drive(STABLE + 1, 1, 0, seg_of(lit_of(9)), 7'h7f);
    checks++; if (vcount != 0) begin errors++; $display("FAIL midrst_early_accept got %0d pulses want 0", vcount); end
    drive(1, 1, 0, seg_of(lit_of(9)), 7'h7f);
    checks++; if (byte_valid !== 1'b1) begin errors++; $display("FAIL midrst_accept got %b want 1", byte_valid); end
    checks++; if (byte_out !== 8'hC9) begin errors++; $display("FAIL midrst_byte2 got %h want c9", byte_out); end
  endtask

  task automatic test_contention();
    do_reset();
    drive(6, 0, 1, 7'h7f, seg_of(lit_of(14)));
    drive(2, 0, 0, 7'h7f, 7'h7f);
    vcount = 0; ecount = 0;
    drive(3, 1, 0, seg_of(lit_of(1)), 7'h7f);
    drive(1, 1, 1, seg_of(lit_of(1)), seg_of(lit_of(14)));
    drive(5, 1, 0, seg_of(lit_of(1)), 7'h7f);
    checks++; if (vcount != 0) begin errors++; $display("FAIL contention_restart got %0d pulses want 0", vcount); end
    drive(2, 1, 0, seg_of(lit_of(1)), 7'h7f);
    checks++; if (vcount != 1) begin errors++; $display("FAIL contention_accept got %0d pulses want 1", vcount); end
    checks++; if (byte_out !== 8'hE1) begin errors++; $display("FAIL contention_byte got %h want e1", byte_out); end
    checks++; if (ecount != 1) begin errors++; $display("FAIL contention_pat_err got %0d pulses want 1", ecount); end
`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
    checks++; if (err_count !== 8'h01) begin errors++; $display("FAIL contention_err_count got %h want 01", err_count); end
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 300; n++) begin
      int len, mode;
      bit x0, x1;
      logic [6:0] pa, pb;
      len = int'($urandom_range(1, 9)); mode = int'($urandom_range(0, 9));
      pa = rand_pat(); pb = rand_pat();
      x0 = (mode >= 2 && mode <= 4) || mode == 9;
      x1 = (mode >= 5 && mode <= 7);
      if (mode == 8) begin x0 = 1; x1 = 1; len = 1; end
      for (int c = 0; c < len; c++) begin
        if (mode == 9 && c % 3 == 2) pa = rand_pat();
        tick(x0, x1, pa, pb);
        checks++;
        if (byte_valid !== m_valid || byte_out !== m_byte || stale !== m_stale || pat_err !== m_err) begin
          errors++;
          $display("FAIL random seg %0d: got v=%b b=%h s=%b e=%b want v=%b b=%h s=%b e=%b",
                   n, byte_valid, byte_out, stale, pat_err, m_valid, m_byte, m_stale, m_err);
        end
`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
        checks++;
        if (err_count !== 8'(m_errcnt)) begin
          errors++; $display("FAIL random_err_count got %h want %h", err_count, 8'(m_errcnt));
        end
`endif
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_pair();
    test_toggle();
    test_illegal();
    test_stale();
    test_reset_mid();
    test_contention();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
